wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 172 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns 34-bit host commands into single Wishbone (pipelined)
// bus cycles. The host can set an auto-incrementing address, then issue writes
// and reads. Every command produces exactly one response pulse.
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort bus cycles that
// get no ack/err within TIMEOUT_CYCLES cycles.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_stb,
    input  logic [33:0] cmd_word,
    output logic        cmd_busy,
    output logic        rsp_stb,
    output logic [33:0] rsp_word,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [29:0] wb_addr,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_sel,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic [31:0] wb_idata
);

    typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT} state_t;

    // Reject an out-of-range parameter at elaboration time.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
    end

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic        inc_q, inc_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [29:0] wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        rsp_stb_q, rsp_stb_d;
    logic [33:0] rsp_word_q, rsp_word_d;
    logic        done;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
`endif

    // Next-state / next-output computation for the command FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        inc_d      = inc_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        rsp_stb_d  = 1'b0;
        rsp_word_d = rsp_word_q;
        done       = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_stb) begin
                    case (cmd_word[33:32])
                        2'b00: begin
                            // Echo the newly loaded address and increment flag.
                            addr_d     = cmd_word[31:2];
                            inc_d      = ~cmd_word[0];
                            rsp_stb_d  = 1'b1;
                            rsp_word_d = {2'b11, cmd_word[31:2], 1'b0, ~cmd_word[0]};
                        end
                        2'b01, 2'b10: begin
                            state_d   = BUS_REQ;
                            cyc_d     = 1'b1;
                            stb_d     = 1'b1;
                            we_d      = (cmd_word[33:32] == 2'b01);
                            wb_addr_d = addr_q;
                            wb_data_d = cmd_word[31:0];
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                            tmo_d     = '0;
`endif
                        end
                        default: begin
                            rsp_stb_d  = 1'b1;
                            rsp_word_d = {2'b10, 32'h2};
                        end
                    endcase
                end
            end
            default: begin
                // Error wins over a simultaneous ack.
                if (wb_err) begin
                    done       = 1'b1;
                    rsp_word_d = {2'b10, 32'h0};
                end else if (wb_ack) begin
                    done       = 1'b1;
                    rsp_word_d = we_q ? {2'b00, 32'h0} : {2'b01, wb_idata};
                    if (inc_q) addr_d = addr_q + 30'd1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    done       = 1'b1;
                    rsp_word_d = {2'b10, 32'h1};
`endif
                end else begin
                    if (state_q == BUS_REQ && !wb_stall) begin
                        state_d = BUS_WAIT;
                        stb_d   = 1'b0;
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    tmo_d = tmo_q + 16'd1;
`endif
                end
                if (done) begin
                    state_d   = IDLE;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    rsp_stb_d = 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs; reset abandons any bus cycle silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            inc_q      <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            rsp_stb_q  <= 1'b0;
            rsp_word_q <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inc_q      <= inc_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            rsp_stb_q  <= rsp_stb_d;
            rsp_word_q <= rsp_word_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign cmd_busy = (state_q != IDLE);
    assign rsp_stb  = rsp_stb_q;
    assign rsp_word = rsp_word_q;
    assign wb_cyc   = cyc_q;
    assign wb_stb   = stb_q;
    assign wb_we    = we_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_sel   = 4'hF;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: expected responses are queued when a
// command is issued and compared whenever rsp_stb is seen.
module tb_wb_cmd_master;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_stb = 1'b0;
    logic [33:0] cmd_word = '0;
    logic        cmd_busy, rsp_stb, wb_cyc, wb_stb, wb_we;
    logic [33:0] rsp_word;
    logic [29:0] wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_sel;
    logic        wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
    logic [31:0] wb_idata = '0;

    int total = 0;
    int bad = 0;
    logic [33:0] sb_q[$];

    wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .cmd_stb(cmd_stb), .cmd_word(cmd_word),
        .cmd_busy(cmd_busy), .rsp_stb(rsp_stb), .rsp_word(rsp_word),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_sel(wb_sel), .wb_stall(wb_stall),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_idata(wb_idata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_stb === 1'b1) begin
            if (sb_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_word", rsp_word, sb_q.pop_front());
        end
    end

    // Issue one command; returns at the negedge of the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [31:0] pl);
        int n = 0;
        while (cmd_busy && n < 50) begin @(negedge clk); n++; end
        if (cmd_busy) chk("busy_timeout", 1, 0);
        cmd_stb  = 1'b1;
        cmd_word = {op, pl};
        @(negedge clk);
        cmd_stb  = 1'b0;
    endtask

    // Ack the current bus cycle in this cycle; response appears next cycle.
    task automatic ack_now(input logic a, input logic e, input logic [31:0] d);
        wb_ack = a; wb_err = e; wb_idata = d;
        @(negedge clk);
        wb_ack = 1'b0; wb_err = 1'b0;
    endtask

    initial begin
        int lows;
        // Reset values
        @(negedge clk);
        chk("rst_busy", cmd_busy, 0);
        chk("rst_cyc", {wb_cyc, wb_stb, wb_we}, 0);
        chk("rst_rsp", {rsp_stb, rsp_word}, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_sel", wb_sel, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Set address 0x100 -> addr 0x40, inc=1
        sb_q.push_back({2'b11, 32'h0000_0101});
        send(2'b00, 32'h0000_0100);
        chk("sa_rsp_stb", rsp_stb, 1);
        chk("sa_no_cyc", wb_cyc, 0);
        chk("sa_busy", cmd_busy, 0);

        // Write with 2 stall cycles, ack one cycle after stb drops
        wb_stall = 1'b1;
        sb_q.push_back({2'b00, 32'h0});
        send(2'b01, 32'hDEADBEEF);
        chk("wr_cyc_stb", {wb_cyc, wb_stb, wb_we}, 3'b111);
        chk("wr_addr", wb_addr, 30'h40);
        chk("wr_data", wb_data, 32'hDEADBEEF);
        chk("wr_busy", cmd_busy, 1);
        @(negedge clk);
        chk("wr_stall_stb", wb_stb, 1);
        cmd_stb = 1'b1; cmd_word = {2'b00, 32'h0000_0F00};   // ignored while busy
        @(negedge clk);
        cmd_stb = 1'b0;
        wb_stall = 1'b0;
        @(negedge clk);
        chk("wr_wait", {wb_cyc, wb_stb}, 2'b10);
        ack_now(1'b1, 1'b0, 32'h0);
        chk("wr_done", {wb_cyc, wb_stb, cmd_busy, rsp_stb}, 4'b0001);
        @(negedge clk);
        chk("wr_rsp_single", rsp_stb, 0);

        // Second write lands on incremented address
        sb_q.push_back({2'b00, 32'h0});
        send(2'b01, 32'h1111_1111);
        chk("wr2_addr", wb_addr, 30'h41);
        ack_now(1'b1, 1'b0, 32'h0);

        // Read acked in first stb cycle
        sb_q.push_back({2'b01, 32'h12345678});
        send(2'b10, 32'h0);
        chk("rd_addr_we", {wb_addr, wb_we}, {30'h42, 1'b0});
        ack_now(1'b1, 1'b0, 32'h12345678);
        chk("rd_latency", rsp_stb, 1);

        // Wrap at the top of the address space, then ack+err
        sb_q.push_back({2'b11, 32'hFFFF_FFFD});
        send(2'b00, 32'hFFFF_FFFC);
        sb_q.push_back({2'b01, 32'hAAAA_5555});
        send(2'b10, 32'h0);
        chk("wrap_rd1_addr", wb_addr, 30'h3FFFFFFF);
        ack_now(1'b1, 1'b0, 32'hAAAA_5555);
        sb_q.push_back({2'b10, 32'h0});
        send(2'b10, 32'h0);
        chk("wrap_rd2_addr", wb_addr, 30'h0);
        ack_now(1'b1, 1'b1, 32'hFFFF_FFFF);
        sb_q.push_back({2'b01, 32'h0BAD_F00D});
        send(2'b10, 32'h0);
        chk("err_no_inc", wb_addr, 30'h0);
        ack_now(1'b1, 1'b0, 32'h0BAD_F00D);

        // Reserved opcode
        sb_q.push_back({2'b10, 32'h2});
        send(2'b11, 32'h1234_5678);
        chk("rsv_no_cyc", {wb_cyc, cmd_busy}, 0);

        // Non-incrementing address; error in BUS_WAIT
        sb_q.push_back({2'b11, 32'h0000_0200});
        send(2'b00, 32'h0000_0201);
        sb_q.push_back({2'b00, 32'h0});
        send(2'b01, 32'h5555_AAAA);
        chk("noinc_addr1", wb_addr, 30'h80);
        ack_now(1'b1, 1'b0, 32'h0);
        sb_q.push_back({2'b10, 32'h0});
        send(2'b01, 32'h0);
        chk("noinc_addr2", wb_addr, 30'h80);
        @(negedge clk);
        chk("err_wait", {wb_cyc, wb_stb}, 2'b10);
        ack_now(1'b0, 1'b1, 32'h0);

        // Silent slave
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        sb_q.push_back({2'b10, 32'h1});
        send(2'b10, 32'h0);
        lows = 0;
        for (int i = 1; i < 20 && wb_cyc; i++) begin @(negedge clk); lows = i; end
        chk("tmo_cycles", lows, TMO);
        chk("tmo_rsp", rsp_stb, 1);
`else
        sb_q.push_back({2'b01, 32'hCAFE_0001});
        send(2'b10, 32'h0);
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            if (!wb_cyc) lows++;
            @(negedge clk);
        end
        chk("no_tmo_cyc_lows", lows, 0);
        ack_now(1'b1, 1'b0, 32'hCAFE_0001);
`endif

        // Reset in the middle of BUS_WAIT: abandon silently
        send(2'b01, 32'h7777_7777);
        @(negedge clk);
        chk("rst_mid_wait", {wb_cyc, wb_stb}, 2'b10);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_cyc", {wb_cyc, wb_stb, cmd_busy, rsp_stb}, 0);
        @(negedge clk);
        chk("rst_mid_word", rsp_word, 0);
        reset = 1'b1;
        @(negedge clk);
        sb_q.push_back({2'b00, 32'h0});
        send(2'b01, 32'h8888_8888);
        chk("post_rst_wr", {wb_cyc, wb_we, wb_addr}, {1'b1, 1'b1, 30'h0});
        chk("post_rst_data", wb_data, 32'h8888_8888);
        ack_now(1'b1, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_left", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
